// File: rtl/text_blit_sequencer.sv
// rtl/text_blit_sequencer.sv - character FIFO feeding a char-blitter slave through a master port
module text_blit_sequencer #(
    parameter int XRES       = 640,
    parameter int COLS       = 80,
    parameter int ROWS       = 60,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clock,
    input  logic        clock_areset_n,
    input  logic [3:0]  s_address,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    input  logic        s_read,
    input  logic        s_write,
    output logic        s_waitrequest,
    output logic [3:0]  m_address,
    output logic [31:0] m_writedata,
    input  logic [31:0] m_readdata,
    output logic        m_read,
    output logic        m_write,
    input  logic        m_waitrequest
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_L = FIFO_DEPTH[AW:0];

    typedef enum logic [3:0] {
        IDLE, FETCH, SET_PTR, SET_CHR, SET_RGB, GO, SETTLE, POLL, ADVANCE
    } state_t;

    state_t      r_state, w_next;
    logic [6:0]  r_fifo [FIFO_DEPTH];
    logic [AW:0] r_wr_ptr, r_rd_ptr, w_level;
    logic        w_empty, w_full, w_push, w_pop, w_busy;
    logic [6:0]  w_head, r_char;
    logic        r_enable, r_overflow, r_home_pend;
    logic [31:0] r_base;
    logic [15:0] r_rgb;
    logic [7:0]  r_row, r_col, w_row_inc;
    logic [1:0]  r_settle;
    logic        w_cfg_wr0, w_home_cmd, w_push_req;
    logic [31:0] w_ptr;
    logic        r_m_read, r_m_write, w_m_read, w_m_write;
    logic [3:0]  r_m_address, w_m_address;
    logic [31:0] r_m_writedata, w_m_writedata;
    logic        w_unused;

    assign w_unused      = ^{m_readdata[31:2], m_readdata[0]};
    assign s_waitrequest = 1'b0;
    assign m_read        = r_m_read;
    assign m_write       = r_m_write;
    assign m_address     = r_m_address;
    assign m_writedata   = r_m_writedata;

    assign w_level    = r_wr_ptr - r_rd_ptr;
    assign w_empty    = (w_level == '0);
    assign w_full     = (w_level == DEPTH_L);
    assign w_head     = r_fifo[r_rd_ptr[AW-1:0]];
    assign w_cfg_wr0  = s_write && (s_address == 4'h0);
    assign w_home_cmd = w_cfg_wr0 && s_writedata[1];
    assign w_push_req = s_write && (s_address == 4'h3);
    assign w_push     = w_push_req && !w_full;
    assign w_pop      = (r_state == FETCH);
    assign w_busy     = (r_state != IDLE);
    assign w_row_inc  = (r_row == 8'(ROWS - 1)) ? 8'd0 : r_row + 8'd1;
    assign w_ptr      = r_base + (32'(r_row) * 32'(XRES) * 32'd16) + {20'b0, r_col, 4'b0};

    always_comb begin
        s_readdata = '0;
        if (s_read) begin
            case (s_address)
                4'h0:    s_readdata = {27'b0, r_overflow, w_empty, w_full, w_busy, r_enable};
                4'h1:    s_readdata = r_base;
                4'h2:    s_readdata = {16'b0, r_rgb};
                4'h3:    s_readdata = 32'(w_level);
                4'h4:    s_readdata = {8'b0, r_row, 8'b0, r_col};
                default: s_readdata = '0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) r_fifo[r_wr_ptr[AW-1:0]] <= s_writedata[6:0];
    end

    always_ff @(posedge clock or negedge clock_areset_n) begin
        if (!clock_areset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
            r_enable   <= 1'b0;
            r_base     <= '0;
            r_rgb      <= '0;
            r_char     <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_char   <= w_head;
            end
            if (w_push_req && w_full) r_overflow <= 1'b1;
            else if (w_cfg_wr0 && s_writedata[4]) r_overflow <= 1'b0;
            if (w_cfg_wr0) r_enable <= s_writedata[0];
            if (s_write && s_address == 4'h1) r_base <= s_writedata;
            if (s_write && s_address == 4'h2) r_rgb <= s_writedata[15:0];
        end
    end

    // Home applies at once when idle; otherwise it waits and overrides the next advance.
    always_ff @(posedge clock or negedge clock_areset_n) begin
        if (!clock_areset_n) begin
            r_row       <= '0;
            r_col       <= '0;
            r_home_pend <= 1'b0;
        end else if ((r_state == IDLE || r_state == ADVANCE) && (w_home_cmd || r_home_pend)) begin
            r_row       <= '0;
            r_col       <= '0;
            r_home_pend <= 1'b0;
        end else begin
            if (w_home_cmd) r_home_pend <= 1'b1;
            if (r_state == FETCH && w_head == 7'h0A) begin
                r_col <= '0;
                r_row <= w_row_inc;
            end else if (r_state == FETCH && w_head == 7'h0D) begin
                r_col <= '0;
            end else if (r_state == ADVANCE) begin
                if (r_col == 8'(COLS - 1)) begin
                    r_col <= '0;
                    r_row <= w_row_inc;
                end else begin
                    r_col <= r_col + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge clock_areset_n) begin
        if (!clock_areset_n) begin
            r_state  <= IDLE;
            r_settle <= '0;
        end else begin
            r_state  <= w_next;
            r_settle <= (r_state == SETTLE) ? r_settle + 2'd1 : 2'd0;
        end
    end

    // Master bus is loaded from the next state, and frozen while a transfer is stalled.
    always_ff @(posedge clock or negedge clock_areset_n) begin
        if (!clock_areset_n) begin
            r_m_read      <= 1'b0;
            r_m_write     <= 1'b0;
            r_m_address   <= '0;
            r_m_writedata <= '0;
        end else if (!((r_m_read || r_m_write) && m_waitrequest)) begin
            r_m_read      <= w_m_read;
            r_m_write     <= w_m_write;
            r_m_address   <= w_m_address;
            r_m_writedata <= w_m_writedata;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_m_read      = 1'b0;
        w_m_write     = 1'b0;
        w_m_address   = '0;
        w_m_writedata = '0;
        case (r_state)
            IDLE:    if (r_enable && !w_empty) w_next = FETCH;
            FETCH:   w_next = (w_head < 7'h20) ? IDLE : SET_PTR;
            SET_PTR: if (!m_waitrequest) w_next = SET_CHR;
            SET_CHR: if (!m_waitrequest) w_next = SET_RGB;
            SET_RGB: if (!m_waitrequest) w_next = GO;
            GO:      if (!m_waitrequest) w_next = SETTLE;
            SETTLE:  if (r_settle == 2'd2) w_next = POLL;
            POLL:    if (!m_waitrequest && !m_readdata[1]) w_next = ADVANCE;
            ADVANCE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
        case (w_next)
            SET_PTR: begin w_m_write = 1'b1; w_m_address = 4'h1; w_m_writedata = w_ptr; end
            SET_CHR: begin w_m_write = 1'b1; w_m_address = 4'h2; w_m_writedata = {25'b0, r_char}; end
            SET_RGB: begin w_m_write = 1'b1; w_m_address = 4'h3; w_m_writedata = {16'b0, r_rgb}; end
            GO:      begin w_m_write = 1'b1; w_m_address = 4'h0; w_m_writedata = 32'h1; end
            POLL:    begin w_m_read = 1'b1; w_m_address = 4'h0; end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_text_blit_sequencer.sv
// tb/tb_text_blit_sequencer.sv - randomized bench with blitter slave model and text-grid reference
module tb_text_blit_sequencer;
    localparam int XRES = 640;
    localparam int COLS = 80;
    localparam int ROWS = 60;
    localparam int DEPTH = 16;

    logic        clock, clock_areset_n;
    logic [3:0]  s_address;
    logic [31:0] s_writedata, s_readdata;
    logic        s_read, s_write, s_waitrequest;
    logic [3:0]  m_address;
    logic [31:0] m_writedata, m_readdata;
    logic        m_read, m_write, m_waitrequest;

    text_blit_sequencer #(.XRES(XRES), .COLS(COLS), .ROWS(ROWS), .FIFO_DEPTH(DEPTH)) dut (
        .clock(clock), .clock_areset_n(clock_areset_n),
        .s_address(s_address), .s_writedata(s_writedata), .s_readdata(s_readdata),
        .s_read(s_read), .s_write(s_write), .s_waitrequest(s_waitrequest),
        .m_address(m_address), .m_writedata(m_writedata), .m_readdata(m_readdata),
        .m_read(m_read), .m_write(m_write), .m_waitrequest(m_waitrequest)
    );

    int n_checks = 0, n_pass = 0;
    logic [35:0] exp_q[$], obs_q[$];
    int mrow = 0, mcol = 0, pend_cnt = 0;
    logic [31:0] mbase = 0;
    logic [15:0] mrgb = 0;
    int stall_pct = 0, chr_stall = 0, poll_fixed = 0, polls_left = 0, n_polls = 0, settle_cnt = -1;

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    // Blitter slave: random stalls, busy for a set number of polls after each GO.
    initial begin
        logic        prev_stall;
        logic [37:0] prev_bus;
        prev_stall = 0;
        prev_bus = '0;
        m_waitrequest = 0;
        m_readdata = 0;
        forever begin
            @(negedge clock);
            if (prev_stall) check_eq("bus_hold", {m_read, m_write, m_address, m_writedata}, prev_bus);
            if (settle_cnt >= 0) begin
                settle_cnt++;
                if (m_read || settle_cnt > 10) begin
                    check_eq("settle_len", settle_cnt, 4);
                    settle_cnt = -1;
                end
            end
            if (chr_stall > 0 && m_write && m_address == 4'h2) begin
                m_waitrequest = 1;
                chr_stall--;
            end else begin
                m_waitrequest = (stall_pct > 0) && ($urandom_range(0, 99) < stall_pct);
            end
            m_readdata = $urandom | 32'h2;
            if (!m_waitrequest && m_write) begin
                obs_q.push_back({m_address, m_writedata});
                if (m_address == 4'h0) begin
                    polls_left = (poll_fixed >= 0) ? poll_fixed : $urandom_range(0, 3);
                    settle_cnt = 0;
                end
            end
            if (!m_waitrequest && m_read) begin
                m_readdata = (polls_left > 0) ? 32'h2 : 32'h0;
                if (polls_left > 0) polls_left--;
                n_polls++;
            end
            prev_stall = m_waitrequest && (m_read || m_write);
            prev_bus = {m_read, m_write, m_address, m_writedata};
        end
    end

    task automatic cfg_write(input logic [3:0] a, input logic [31:0] d);
        s_address = a; s_writedata = d; s_write = 1;
        @(negedge clock);
        s_write = 0;
    endtask

    task automatic cfg_read(input logic [3:0] a, output logic [31:0] d);
        s_address = a; s_read = 1;
        #1 d = s_readdata;
        @(negedge clock);
        s_read = 0;
    endtask

    // Reference: a character either moves the cursor or produces four blitter writes.
    task automatic model_char(input logic [6:0] c);
        if (c == 7'h0A) begin
            mcol = 0; mrow = (mrow + 1) % ROWS;
        end else if (c == 7'h0D) begin
            mcol = 0;
        end else if (c >= 7'h20) begin
            exp_q.push_back({4'h1, mbase + 32'(mrow * XRES * 16 + mcol * 16)});
            exp_q.push_back({4'h2, 25'b0, c});
            exp_q.push_back({4'h3, 16'b0, mrgb});
            exp_q.push_back({4'h0, 32'h1});
            mcol++;
            if (mcol == COLS) begin
                mcol = 0; mrow = (mrow + 1) % ROWS;
            end
        end
    endtask

    task automatic wait_idle();
        logic [31:0] st;
        bit done = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            cfg_read(4'h0, st);
            if (!st[1] && (st[3] || !st[0])) done = 1;
        end
        if (!done) check_eq("idle_timeout", 0, 1);
        pend_cnt = 0;
    endtask

    task automatic push_char(input logic [6:0] c);
        cfg_write(4'h3, {25'b0, c});
        model_char(c);
        pend_cnt++;
        if (pend_cnt == DEPTH) wait_idle();
    endtask

    task automatic compare_q(input string tag);
        check_eq({tag, "_nwrites"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0)
            check_eq({tag, "_write"}, obs_q.pop_front(), exp_q.pop_front());
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic check_cursor(input string tag);
        logic [31:0] d;
        cfg_read(4'h4, d);
        check_eq(tag, d, (32'(mrow) << 16) | 32'(mcol));
    endtask

    task automatic set_base(input logic [31:0] v);
        cfg_write(4'h1, v); mbase = v;
    endtask

    task automatic set_rgb(input logic [31:0] v);
        cfg_write(4'h2, v); mrgb = v[15:0];
    endtask

    initial begin
        logic [31:0] d, v;
        logic [6:0]  c;
        bit          seen;
        s_address = 0; s_writedata = 0; s_read = 0; s_write = 0;
        clock_areset_n = 0;
        repeat (3) @(negedge clock);
        clock_areset_n = 1;
        @(negedge clock);

        cfg_read(4'h0, d); check_eq("rst_status", d, 32'h8);
        cfg_read(4'h3, d); check_eq("rst_level", d, 0);
        check_cursor("rst_cursor");
        check_eq("rst_mbus", {m_read, m_write, m_address, m_writedata}, 0);

        set_base(32'h1000); set_rgb(32'hF800);
        cfg_write(4'h3, 32'h41); model_char(7'h41);
        cfg_write(4'h0, 32'h1);
        wait_idle();
        compare_q("first_blit");
        check_cursor("first_cursor");

        cfg_write(4'h0, 32'h3); mrow = 0; mcol = 0;
        push_char(7'h41); push_char(7'h0A); push_char(7'h42);
        wait_idle();
        compare_q("newline");
        check_cursor("newline_cursor");

        cfg_write(4'h0, 32'h3); mrow = 0; mcol = 0;
        for (int i = 0; i < ROWS - 1; i++) push_char(7'h0A);
        for (int i = 0; i < COLS - 1; i++) push_char(7'h78);
        wait_idle();
        check_cursor("corner_cursor");
        push_char(7'h42);
        wait_idle();
        compare_q("wrap");
        check_cursor("wrap_cursor");

        stall_pct = 30; poll_fixed = -1;
        for (int b = 0; b < 3; b++) begin
            set_base($urandom);
            v = $urandom; set_rgb(v);
            cfg_read(4'h2, d); check_eq("rgb_rb", d, {16'b0, v[15:0]});
            for (int i = 0; i < 12; i++) begin
                case ($urandom_range(0, 9))
                    0: c = 7'h0A;
                    1: c = 7'h0D;
                    2: c = 7'($urandom_range(0, 31));
                    default: c = 7'($urandom_range(32, 127));
                endcase
                push_char(c);
            end
            wait_idle();
            compare_q("rand");
            check_cursor("rand_cursor");
        end

        stall_pct = 0; poll_fixed = 10; chr_stall = 5; n_polls = 0;
        push_char(7'h43);
        wait_idle();
        compare_q("stall");
        check_eq("stall_polls", n_polls, 11);

        poll_fixed = 0;
        cfg_write(4'h0, 32'h0);
        cfg_write(4'h3, 32'h44); cfg_write(4'h3, 32'h45);
        model_char(7'h44);
        cfg_write(4'h0, 32'h1);
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            cfg_read(4'h0, d);
            if (d[1]) seen = 1;
        end
        cfg_write(4'h0, 32'h0);
        wait_idle();
        cfg_read(4'h3, d); check_eq("disable_level", d, 1);
        compare_q("disable");
        cfg_write(4'h0, 32'h1); model_char(7'h45);
        wait_idle();
        compare_q("reenable");

        cfg_write(4'h0, 32'h0);
        for (int i = 0; i < DEPTH + 1; i++) cfg_write(4'h3, 32'(8'h50 + i));
        cfg_read(4'h3, d); check_eq("ovf_level", d, DEPTH);
        cfg_read(4'h0, d); check_eq("ovf_status", d, 32'h14);
        cfg_write(4'h0, 32'h10);
        cfg_read(4'h0, d); check_eq("ovf_clear", d, 32'h4);
        for (int i = 0; i < DEPTH; i++) model_char(7'(8'h50 + i));
        cfg_write(4'h0, 32'h1);
        wait_idle();
        compare_q("ovf_drain");

        poll_fixed = 1000;
        cfg_write(4'h3, 32'h5A);
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clock);
            if (m_read) seen = 1;
        end
        check_eq("poll_reached", seen, 1);
        clock_areset_n = 0;
        #1 check_eq("rst_mread", {m_read, m_write}, 0);
        @(negedge clock);
        polls_left = 0; poll_fixed = 0; settle_cnt = -1;
        obs_q.delete(); exp_q.delete();
        mrow = 0; mcol = 0; mbase = 0; mrgb = 0;
        clock_areset_n = 1;
        @(negedge clock);
        cfg_read(4'h0, d); check_eq("rst2_status", d, 32'h8);
        cfg_read(4'h1, d); check_eq("rst2_base", d, 0);
        check_cursor("rst2_cursor");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
